// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_pkg
// Description : Shared types, constants and the overflow helper for the
//               serial carry-lookahead adder.
// Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow: operands share a sign that the result lacks.
    function automatic logic signed_ovf(input logic sign_a,
                                        input logic sign_b,
                                        input logic sign_s);
        return (sign_a == sign_b) && (sign_s != sign_a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_byte_add.sv
`default_nettype none
// ============================================================================
// Module      : cla_byte_add
// Description : 8-bit carry-lookahead adder slice (flat generate/propagate).
// Revision    : 1.0 - initial release
// ============================================================================
module cla_byte_add
    import cla_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W-1:0] w_g;
    logic [BYTE_W-1:0] w_p;
    logic [BYTE_W:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is a two-level sum of products over all lower bit positions.
    always_comb begin
        logic w_term;
        logic w_acc;
        w_c    = '0;
        w_c[0] = cin;
        for (int k = 1; k <= BYTE_W; k++) begin
            w_acc = cin;
            for (int m = 0; m < k; m++) begin
                w_acc = w_acc & w_p[m];
            end
            for (int j = 0; j < k; j++) begin
                w_term = w_g[j];
                for (int m = j + 1; m < k; m++) begin
                    w_term = w_term & w_p[m];
                end
                w_acc = w_acc | w_term;
            end
            w_c[k] = w_acc;
        end
    end

    assign sum  = w_p ^ w_c[BYTE_W-1:0];
    assign cout = w_c[BYTE_W];

endmodule
`default_nettype wire

// File: rtl/cla_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_serial_adder
// Description : Multi-cycle W-bit add/subtract, one byte per cycle through a
//               single CLA slice, with valid/ready on operands and result.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int NB = 4,
    localparam int W = BYTE_W * NB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int          CW   = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    state_t        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [W-1:0]  a_sh_q,      a_sh_d;
    logic [W-1:0]  b_sh_q,      b_sh_d;
    logic          carry_q,     carry_d;
    logic          sign_a_q,    sign_a_d;
    logic          sign_b_q,    sign_b_d;
    logic [W-1:0]  sum_q,       sum_d;
    logic          cout_q,      cout_d;
    logic          ovf_q,       ovf_d;
    logic          out_valid_q, out_valid_d;

    logic [BYTE_W-1:0] w_slice_sum;
    logic              w_slice_cout;

    cla_byte_add u_slice (
        .a    (a_sh_q[BYTE_W-1:0]),
        .b    (b_sh_q[BYTE_W-1:0]),
        .cin  (carry_q),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        carry_d     = carry_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = sub ? ~b : b;
                    carry_d  = sub ? 1'b1 : cin;
                    sign_a_d = a[W-1];
                    sign_b_d = sub ? ~b[W-1] : b[W-1];
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Bytes enter from the top so byte i settles at its own lane.
                sum_d   = {w_slice_sum, sum_q[W-1:BYTE_W]};
                a_sh_d  = a_sh_q >> BYTE_W;
                b_sh_d  = b_sh_q >> BYTE_W;
                carry_d = w_slice_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d       = '0;
                    cout_d      = w_slice_cout;
                    ovf_d       = signed_ovf(sign_a_q, sign_b_q, w_slice_sum[BYTE_W-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            carry_q     <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            carry_q     <= carry_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_serial_adder
// Description : Directed self-checking bench for cla_serial_adder (NB=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_serial_adder;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int accept_cyc;

    cla_serial_adder #(.NB(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present an operand set and return #1 after the accepting edge.
    task automatic issue(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tcin, input logic tsub, input bit keep_valid);
        int n;
        a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_ready_before_accept"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        if (!keep_valid) in_valid = 1'b0;
        check({tag, "_in_ready_low_in_run"}, in_ready, 1'b0);
    endtask

    task automatic wait_result(input string tag, input logic [W-1:0] exp_sum,
                               input logic exp_cout, input logic exp_ovf);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_latency"}, n, NB);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_cout"}, cout, exp_cout);
        check({tag, "_ovf"}, ovf, exp_ovf);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_drained"}, out_valid, 1'b0);
        check({tag, "_in_ready_after"}, in_ready, 1'b1);
    endtask

    initial begin
        bit seen;
        int t1;
        logic [W-1:0] held_sum;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 32'h0);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Carry across a byte boundary, with latency check.
        issue("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        wait_result("t1", 32'h0000_0100, 1'b0, 1'b0);
        drain("t1");

        issue("t2a", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        wait_result("t2a", 32'h0000_0000, 1'b1, 1'b0);
        drain("t2a");

        issue("t2b", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        wait_result("t2b", 32'h8000_0000, 1'b0, 1'b1);
        drain("t2b");

        issue("t3a", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        wait_result("t3a", 32'h7FFF_FFFF, 1'b1, 1'b1);
        drain("t3a");

        issue("t3b", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0);
        wait_result("t3b", 32'hFFFF_FFFE, 1'b0, 1'b0);
        drain("t3b");

        // Backpressure: result must hold while operands keep changing.
        out_ready = 1'b0;
        issue("t4", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
        wait_result("t4", 32'h2345_6789, 1'b0, 1'b0);
        held_sum = 32'h2345_6789;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; sub = i[0]; cin = 1'b1;
            @(posedge clk); #1;
            check("t4_hold_sum", sum, held_sum);
            check("t4_hold_cout", cout, 1'b0);
            check("t4_hold_ovf", ovf, 1'b0);
            check("t4_hold_valid", out_valid, 1'b1);
            check("t4_hold_in_ready", in_ready, 1'b0);
        end
        drain("t4");
        in_valid = 1'b0;

        // Asynchronous reset in the second RUN cycle aborts the operation.
        issue("t5", 32'h1122_3344, 32'h0101_0101, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", out_valid, 1'b0);
        check("t5_rst_sum", sum, 32'h0);
        check("t5_rst_in_ready", in_ready, 1'b1);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("t5_no_stale_valid", seen, 1'b0);
        issue("t5b", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b0);
        wait_result("t5b", 32'h0000_0030, 1'b0, 1'b0);
        drain("t5b");

        // Back-to-back with in_valid held high throughout.
        issue("t6a", 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
        t1 = accept_cyc;
        a = 32'h0000_0010; b = 32'h0000_0010; cin = 1'b0; sub = 1'b1;
        wait_result("t6a", 32'h8000_0000, 1'b0, 1'b1);
        drain("t6a");
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t6_interval", cyc - t1, NB + 2);
        check("t6b_in_ready_low", in_ready, 1'b0);
        wait_result("t6b", 32'h0000_0000, 1'b1, 1'b0);
        drain("t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
